// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline.
// It produces the EX-stage forwarding selects, the load-use stall, the taken-branch
// flush and a whole-pipe freeze while data memory is busy. A watchdog latches an
// error after a long busy stretch.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
// Without that macro, stall_cnt and flush_cnt are tied to zero.
// Handshake: there is none. Every control output is a combinational function of the
// current-cycle stage info and the registered FSM state, with zero-cycle latency.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int ZERO_REG    = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  branch_taken_ex,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  idex_bubble,
    output logic                  memwb_bubble,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  hazard_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FREEZE = 2'd1, ST_ERR = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              load_use;

    // A producer matches a consumer register when it is valid and the addresses are equal.
    // With ZERO_REG set, x0 is never considered a match.
    function automatic logic reg_match(input logic vld, input logic [REG_ADDR_W-1:0] r,
                                       input logic [REG_ADDR_W-1:0] x);
        return vld && (x == r) && ((ZERO_REG == 0) || (r != '0));
    endfunction

    // A load in EX whose destination is read by the valid instruction in ID.
    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read &&
                   ((id_uses_rs1 && reg_match(1'b1, id_rs1, ex_rd)) ||
                    (id_uses_rs2 && reg_match(1'b1, id_rs2, ex_rd)));
    end

    // State and busy-watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic. wait_cnt counts consecutive busy cycles and saturates instead of wrapping.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    state_d    = ST_FREEZE;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_FREEZE: begin
                if (!dmem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) begin
                    state_d = ST_ERR;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic. Priority is ERR, then freeze, then flush, then load-use stall, then normal.
    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        forward_a    = 2'b00;
        forward_b    = 2'b00;
        if (!rst && (state_q != ST_ERR)) begin
            // EX/MEM is the younger producer, so it wins over MEM/WB.
            if (mem_reg_write && reg_match(mem_valid, ex_rs1, mem_rd))      forward_a = 2'b10;
            else if (wb_reg_write && reg_match(wb_valid, ex_rs1, wb_rd))    forward_a = 2'b01;
            if (mem_reg_write && reg_match(mem_valid, ex_rs2, mem_rd))      forward_b = 2'b10;
            else if (wb_reg_write && reg_match(wb_valid, ex_rs2, wb_rd))    forward_b = 2'b01;

            if (dmem_busy) begin
                // Hold everything upstream of MEM, including any taken branch sitting in EX.
                memwb_bubble = 1'b1;
            end else if (branch_taken_ex) begin
                // The instruction in ID is wrong-path, so a load-use stall on it is irrelevant.
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (load_use) begin
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end
        end
    end

    assign hazard_err = (state_q == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters for stall cycles (pc held outside ERR) and flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (state_q != ST_ERR) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ifid_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
